// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue register in front of the ALU. A 32-bit MIPS instruction and the
// register-file values for rs/rt are decoded into a 4-bit aluoperation code,
// the two ALU operands and the EX/MEM/WB control bits. The decoded entry is
// held in a single-entry valid/ready register. No skid buffer is used, so
// in_ready is a combinational function of the held entry and out_ready.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   IF/ID handshake; capture on in_valid && in_ready && !flush
//   in_instr         instruction word
//   in_rs_data       register-file value for rs
//   in_rt_data       register-file value for rt
//   flush            branch redirect: drop the held entry and any capture
//   out_valid/ready  EX handshake
//   out_aluop        aluoperation (ADD SUB AND OR XOR BEQ BNE SLT SLL)
//   out_data1/2      ALU operands
//   out_store_data   rt value for sw (0 for every other instruction)
//   out_dest         destination register
//   out_reg_write    write-back enable
//   out_mem_read     lw
//   out_mem_write    sw
//   out_branch       beq/bne, EX resolves using the ALU bcond output
//   out_illegal      unsupported opcode/funct, entry still flows to EX
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_aluop,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_store_data,
    output logic [4:0]        out_dest,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_illegal
);

    // aluoperation codes
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [OP_W-1:0] ALU_BEQ = 4'b0101;
    localparam logic [OP_W-1:0] ALU_BNE = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b1000;

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // One decoded issue entry; this is exactly what the EX side sees.
    typedef struct packed {
        logic [OP_W-1:0]   aluop;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              illegal;
    } issue_ent_t;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = in_instr[31:26];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign shamt  = in_instr[10:6];
    assign funct  = in_instr[5:0];
    assign imm    = in_instr[15:0];

    // The rs index is resolved by the register file upstream; only its data
    // is needed here.
    logic unused_rs_field;
    assign unused_rs_field = ^in_instr[25:21];

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_zext;

    assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext   = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    issue_ent_t dec;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.dest      = rd;
                dec.reg_write = (rd != 5'd0);
                dec.data1     = in_rs_data;
                dec.data2     = in_rt_data;
                case (funct)
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_XOR:         dec.aluop = ALU_XOR;
                    F_SLT:         dec.aluop = ALU_SLT;
                    F_SLL: begin
                        // the shifted value is rt, the amount is the shamt field
                        dec.aluop = ALU_SLL;
                        dec.data1 = in_rt_data;
                        dec.data2 = shamt_zext;
                    end
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.data1     = in_rs_data;
                dec.dest      = rt;
                dec.reg_write = (rt != 5'd0);
                case (opcode)
                    OP_SLTI: begin dec.aluop = ALU_SLT; dec.data2 = imm_sext; end
                    OP_ANDI: begin dec.aluop = ALU_AND; dec.data2 = imm_zext; end
                    OP_ORI:  begin dec.aluop = ALU_OR;  dec.data2 = imm_zext; end
                    OP_XORI: begin dec.aluop = ALU_XOR; dec.data2 = imm_zext; end
                    default: begin dec.aluop = ALU_ADD; dec.data2 = imm_sext; end
                endcase
            end
            OP_LW: begin
                dec.aluop     = ALU_ADD;
                dec.data1     = in_rs_data;
                dec.data2     = imm_sext;
                dec.dest      = rt;
                dec.reg_write = (rt != 5'd0);
                dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                // address = rs + imm; rt travels separately as the store value
                dec.aluop      = ALU_ADD;
                dec.data1      = in_rs_data;
                dec.data2      = imm_sext;
                dec.store_data = in_rt_data;
                dec.mem_write  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // the ALU compares rs with rt; the target is computed elsewhere
                dec.aluop  = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                dec.data1  = in_rs_data;
                dec.data2  = in_rt_data;
                dec.branch = 1'b1;
            end
            default: begin
                dec         = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-entry valid/ready register
    // ------------------------------------------------------------------
    issue_ent_t ent_q;
    logic       valid_q;
    logic       capture;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Data fields only load on capture, so they hold while stalled. A flush
    // only clears the valid bit; the stale payload is qualified by out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (capture)
                valid_q <= 1'b1;
            else if (out_ready)
                valid_q <= 1'b0;

            if (capture)
                ent_q <= dec;
        end
    end

    assign out_valid      = valid_q;
    assign out_aluop      = ent_q.aluop;
    assign out_data1      = ent_q.data1;
    assign out_data2      = ent_q.data2;
    assign out_store_data = ent_q.store_data;
    assign out_dest       = ent_q.dest;
    assign out_reg_write  = ent_q.reg_write;
    assign out_mem_read   = ent_q.mem_read;
    assign out_mem_write  = ent_q.mem_write;
    assign out_branch     = ent_q.branch;
    assign out_illegal    = ent_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue register that feeds the ALU. It decodes a 32-bit MIPS instruction plus register-file read data into the ALU's 4-bit aluoperation code and the data1/data2 operands, and holds the result in a valid/ready pipeline register for the EX stage. It supports stall via back-pressure and a flush for branch redirect.

Parameters:
DATA_W, 32, operand width (ALU operand width is fixed at 32)
OP_W, 4, aluoperation code width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_rs_data  in  32  register-file value for rs
in_rt_data  in  32  register-file value for rt
flush  in  1  discard the held entry and any capture this cycle
out_valid  out  1  EX-side entry valid
out_ready  in  1  EX consumes the entry this cycle
out_aluop  out  4  aluoperation code
out_data1  out  32  ALU data1
out_data2  out  32  ALU data2
out_store_data  out  32  rt value, used for sw
out_dest  out  5  destination register (rd for R-type, rt for I-type, 0 otherwise)
out_reg_write  out  1  result is written back
out_mem_read  out  1  lw
out_mem_write  out  1  sw
out_branch  out  1  beq/bne; EX uses the ALU bcond output
out_illegal  out  1  unsupported opcode/funct

Behaviour:
- aluoperation encoding is fixed: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 BEQ, 0110 BNE, 0111 SLT, 1000 SLL.
- R-type decode (opcode 0x00):
  - funct 0x20/0x21: ADD. funct 0x22/0x23: SUB. 0x24: AND. 0x25: OR. 0x26: XOR. 0x2A: SLT.
  - For these, data1 = rs and data2 = rt.
  - funct 0x00 (SLL): data1 = rt, data2 = zero-extended shamt (instr[10:6]).
  - All R-types: dest = rd, reg_write = 1, except when rd = 0, where reg_write = 0.
- I-type decode (data1 = rs):
  - 0x08/0x09: ADD, sign-extended imm.
  - 0x0A: SLT, sign-extended imm.
  - 0x0C: AND, zero-extended imm. 0x0D: OR, zero-extended imm. 0x0E: XOR, zero-extended imm.
  - All of the above: dest = rt, reg_write = (rt != 0).
  - 0x23 lw: ADD, sign-extended imm, mem_read = 1, dest = rt, reg_write = (rt != 0).
  - 0x2B sw: ADD, sign-extended imm, mem_write = 1, store_data = rt, reg_write = 0.
  - 0x04 beq: BEQ, data2 = rt, branch = 1. 0x05 bne: BNE, data2 = rt, branch = 1.
- Any other opcode/funct: illegal = 1, aluop = ADD, data1 = data2 = 0, and all control bits 0. The entry still flows through so EX can trap.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single entry, no skid).
  - Capture on in_valid && in_ready && !flush. out_valid is set the next cycle, so latency is 1 cycle.
  - Hold: while out_valid && !out_ready, every out_* signal stays stable and in_ready = 0.
  - A consume and a capture in the same cycle gives back-to-back throughput of 1 per cycle.
  - A consume with no capture clears out_valid.
- flush: out_valid = 0 at the next edge regardless of out_ready, and nothing is captured that cycle. Data fields may keep stale values; only out_valid is qualified.
- Reset, asynchronous and active-low: out_valid = 0, all data outputs = 0, aluop = 0000, all control bits = 0. Deassertion mid-stream starts from the empty state, with in_ready = 1.
- Output fields are registered, never combinational from the inputs.

Test Plan:
- Reset: rst_n = 0 mid-transfer with out_valid = 1 -> out_valid = 0 and all outputs = 0 immediately, with no clock edge required.
- Decode: add $3,$1,$2 (0x00221820) with rs = 5, rt = 7 -> one cycle later aluop = 0000, data1 = 5, data2 = 7, dest = 3, reg_write = 1.
- Immediates:
  - addi imm 0xFFFF -> data2 = 0xFFFFFFFF.
  - ori imm 0xFFFF -> data2 = 0x0000FFFF, aluop = 0011.
  - sll $2,$4,3 with rt = 9 -> data1 = 9, data2 = 3, aluop = 1000.
- Branches and illegal: beq -> aluop = 0101, branch = 1, reg_write = 0. Opcode 0x3F -> illegal = 1, aluop = 0000.
- Back-pressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable throughout. Then out_ready = 1 with streaming input -> one instruction per cycle, with order and count preserved over 20 instructions.
- Flush: flush together with in_valid = 1 and out_valid = 1 -> next cycle out_valid = 0, and the flushed instruction never appears on the output.
